// File: rtl/encap_pio_master_pkg.sv
// encap_pio_master_pkg
//   Shared constants and types for the encap PIO bus initiator.
//   PIO_NBITS     : width of PIO address / data buses
//   PIO_TMO_NBITS : width of the saturating timeout counter
//   pio_mst_state_t : 2-bit FSM encoding (IDLE, ISSUE, WAIT, DRAIN)
package encap_pio_master_pkg;

  localparam int PIO_NBITS     = 32;
  localparam int PIO_TMO_NBITS = 10;

  typedef enum logic [1:0] {
    PIO_MST_IDLE  = 2'd0,
    PIO_MST_ISSUE = 2'd1,
    PIO_MST_WAIT  = 2'd2,
    PIO_MST_DRAIN = 2'd3
  } pio_mst_state_t;

endpackage

// File: rtl/encap_pio_master_if.sv
// encap_pio_master_if
//   Bundles the host command/response port and the PIO bus of the encap
//   PIO initiator.
//   master modport : the initiator (drives cmd_ready, rsp_*, reg_*)
//   slave modport  : host + responder side (drives cmd_*, pio_*)
interface encap_pio_master_if;
  import encap_pio_master_pkg::*;

  // host command / response
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_wr;
  logic [PIO_NBITS-1:0] cmd_addr;
  logic [PIO_NBITS-1:0] cmd_wdata;
  logic                 rsp_valid;
  logic                 rsp_err;
  logic [PIO_NBITS-1:0] rsp_rdata;

  // PIO bus
  logic                 reg_bs;
  logic                 reg_wr;
  logic                 reg_rd;
  logic [PIO_NBITS-1:0] reg_addr;
  logic [PIO_NBITS-1:0] reg_din;
  logic                 pio_ack;
  logic                 pio_rvalid;
  logic [PIO_NBITS-1:0] pio_rdata;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
    input  pio_ack, pio_rvalid, pio_rdata,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
    output reg_bs, reg_wr, reg_rd, reg_addr, reg_din
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
    output pio_ack, pio_rvalid, pio_rdata,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
    input  reg_bs, reg_wr, reg_rd, reg_addr, reg_din
  );

endinterface

// File: rtl/encap_pio_master_tmo_cnt.sv
// pio_tmo_cnt
//   clk_div-enabled saturating timeout counter.
//   clk  : core clock
//   rstn : asynchronous active-low reset
//   clr  : synchronous clear (wins over en)
//   en   : count enable, one clk_div pulse
//   hit  : high when the count has reached TIMEOUT, including the cycle
//          whose enable pulse is the TIMEOUT-th one
module pio_tmo_cnt
  import encap_pio_master_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [PIO_TMO_NBITS-1:0] TMO     = PIO_TMO_NBITS'(TIMEOUT);
  localparam logic [PIO_TMO_NBITS-1:0] TMO_M1  = PIO_TMO_NBITS'(TIMEOUT - 1);
  localparam logic [PIO_TMO_NBITS-1:0] CNT_MAX = '1;

  logic [PIO_TMO_NBITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + PIO_TMO_NBITS'(1);
    end
  end

  // Look-ahead term lets the FSM complete on the same edge that counts the
  // TIMEOUT-th pulse, so the error response appears one cycle after it.
  assign hit = (cnt_q >= TMO) || (en && (cnt_q == TMO_M1));

endmodule

// File: rtl/encap_pio_master.sv
// encap_pio_master
//   PIO bus initiator: takes one read/write command at a time from the host
//   port, drives the PIO bus, waits for ack / read-valid or a timeout and
//   returns one response per command. The bus is drained (responder inputs
//   both low) before the next command is accepted.
//   Ports:
//     clk     : core clock
//     rstn    : asynchronous active-low reset
//     clk_div : one-clk enable pulse marking the PIO slow-clock edge
//     bus     : command/response + PIO bus (master modport)
//   Parameter TIMEOUT: clk_div ticks in WAIT before an error response
//   (legal 1..1023).
module encap_pio_master
  import encap_pio_master_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clk_div,
  encap_pio_master_if.master  bus
);

  pio_mst_state_t       state_q, state_nxt;
  logic                 wr_q, wr_nxt;
  logic                 bs_q, bs_nxt;
  logic                 wr_stb_q, wr_stb_nxt;
  logic                 rd_stb_q, rd_stb_nxt;
  logic [PIO_NBITS-1:0] addr_q, addr_nxt;
  logic [PIO_NBITS-1:0] din_q, din_nxt;
  logic                 rsp_valid_q, rsp_valid_nxt;
  logic                 rsp_err_q, rsp_err_nxt;
  logic [PIO_NBITS-1:0] rsp_rdata_q, rsp_rdata_nxt;

  logic cnt_clr;
  logic cnt_en;
  logic tmo_hit;
  logic done;

  assign cnt_clr = (state_q == PIO_MST_IDLE) && bus.cmd_valid;
  assign cnt_en  = (state_q == PIO_MST_WAIT) && clk_div;
  // Each direction listens only to its own completion input.
  assign done    = wr_q ? bus.pio_ack : bus.pio_rvalid;

  pio_tmo_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .hit  (tmo_hit)
  );

  always_comb begin
    state_nxt     = state_q;
    wr_nxt        = wr_q;
    bs_nxt        = bs_q;
    wr_stb_nxt    = 1'b0;
    rd_stb_nxt    = 1'b0;
    addr_nxt      = addr_q;
    din_nxt       = din_q;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = 1'b0;
    rsp_rdata_nxt = '0;

    case (state_q)
      PIO_MST_IDLE: begin
        if (bus.cmd_valid) begin
          wr_nxt     = bus.cmd_wr;
          addr_nxt   = bus.cmd_addr;
          din_nxt    = bus.cmd_wdata;
          bs_nxt     = 1'b1;
          wr_stb_nxt = bus.cmd_wr;
          rd_stb_nxt = ~bus.cmd_wr;
          state_nxt  = PIO_MST_ISSUE;
        end
      end
      PIO_MST_ISSUE: begin
        state_nxt = PIO_MST_WAIT;
      end
      PIO_MST_WAIT: begin
        // A real completion beats a coincident timeout.
        if (done || tmo_hit) begin
          bs_nxt        = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = ~done;
          rsp_rdata_nxt = (done && !wr_q) ? bus.pio_rdata : '0;
          state_nxt     = PIO_MST_DRAIN;
        end
      end
      PIO_MST_DRAIN: begin
        // Holding here keeps a lingering ack/rvalid from completing the
        // next command.
        if (!bus.pio_ack && !bus.pio_rvalid) begin
          state_nxt = PIO_MST_IDLE;
        end
      end
      default: begin
        state_nxt = PIO_MST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= PIO_MST_IDLE;
      wr_q        <= 1'b0;
      bs_q        <= 1'b0;
      wr_stb_q    <= 1'b0;
      rd_stb_q    <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_nxt;
      wr_q        <= wr_nxt;
      bs_q        <= bs_nxt;
      wr_stb_q    <= wr_stb_nxt;
      rd_stb_q    <= rd_stb_nxt;
      addr_q      <= addr_nxt;
      din_q       <= din_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_err_q   <= rsp_err_nxt;
      rsp_rdata_q <= rsp_rdata_nxt;
    end
  end

  assign bus.cmd_ready = (state_q == PIO_MST_IDLE);
  assign bus.reg_bs    = bs_q;
  assign bus.reg_wr    = wr_stb_q;
  assign bus.reg_rd    = rd_stb_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_din   = din_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule
